// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types for the ROM burst arbiter.
//   arb_state_t : controller state (IDLE waits for a request, STREAM emits words)
//   req_id_t    : requester index, 0 or 1
package rom_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector.
//   valid[1:0]        in  requests from port 0 / port 1
//   last_grant        in  port granted most recently
//   grant_onehot[1:0] out one-hot winner, all zero when nobody requests
//   grant_id          out index of the winner (0 when nobody requests)
module rr_pick2
  import rom_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant_onehot,
  output req_id_t    grant_id
);

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_onehot = 2'b00;
    grant_id     = 1'b0;
    if (valid == 2'b11) begin
      // Tie: the port that did not win last time goes now.
      grant_id = ~last_grant;
    end else if (valid[1]) begin
      grant_id = 1'b1;
    end
    if (|valid) begin
      grant_onehot = grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter: shares one asynchronous-read ROM between two requesters.
// Each requester posts a start address and a word count; bursts are granted
// round-robin at burst boundaries and streamed one word per cycle under
// valid/ready backpressure.
//   clock, reset             single clock, asynchronous active-high reset
//   req{0,1}_valid/addr/len  burst requests (len 0 is legal, yields no data)
//   req{0,1}_ready           request accepted this cycle (IDLE only)
//   rom_addr / rom_dout      external ROM, combinational read
//   out_valid/ready/data     word stream
//   out_id / out_last        burst owner and final-word flag
module rom_burst_arbiter
  import rom_arb_pkg::*;
#(
  parameter  int Nloc  = 16,
  parameter  int Dbits = 4,
  parameter  int Lbits = 4,
  localparam int Abits = (Nloc > 1) ? $clog2(Nloc) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [Abits-1:0] req0_addr,
  input  logic [Lbits-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [Abits-1:0] req1_addr,
  input  logic [Lbits-1:0] req1_len,
  output logic             req1_ready,
  output logic [Abits-1:0] rom_addr,
  input  logic [Dbits-1:0] rom_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Dbits-1:0] out_data,
  output logic             out_id,
  output logic             out_last
);

  arb_state_t       state, state_next;
  logic [Abits-1:0] cur_addr;
  logic [Lbits-1:0] remaining;
  req_id_t          owner;
  req_id_t          last_grant;

  logic [1:0]       grant_onehot;
  req_id_t          grant_id;
  logic             accept;
  logic             fire;
  logic [Abits-1:0] sel_addr;
  logic [Lbits-1:0] sel_len;
  logic [Abits-1:0] addr_inc;

  rr_pick2 u_pick (
    .valid        ({req1_valid, req0_valid}),
    .last_grant   (last_grant),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id)
  );

  // Ready depends only on request valids, state and last_grant; grants are
  // offered only between bursts.
  assign req0_ready = (state == IDLE) && grant_onehot[0];
  assign req1_ready = (state == IDLE) && grant_onehot[1];
  assign accept     = req0_ready || req1_ready;

  assign sel_addr = grant_id ? req1_addr : req0_addr;
  assign sel_len  = grant_id ? req1_len  : req0_len;

  // Explicit wrap so a non-power-of-two depth still returns to word 0.
  assign addr_inc = (cur_addr == Abits'(Nloc - 1)) ? '0 : cur_addr + Abits'(1);

  // Outputs come from registers and the ROM only; out_ready never feeds them.
  assign rom_addr  = cur_addr;
  assign out_data  = rom_dout;
  assign out_valid = (state == STREAM);
  assign out_id    = owner;
  assign out_last  = out_valid && (remaining == Lbits'(1));
  assign fire      = out_valid && out_ready;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (accept && (sel_len != '0)) state_next = STREAM;
      STREAM: if (fire && out_last)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register here sample the
  // pre-edge values, so the order of statements does not matter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;  // port 0 wins the first tie
    end else begin
      state <= state_next;
      if (accept) begin
        // A zero-length grant still counts for fairness.
        cur_addr   <= sel_addr;
        remaining  <= sel_len;
        owner      <= grant_id;
        last_grant <= grant_id;
      end else if (fire) begin
        cur_addr  <= addr_inc;
        remaining <= remaining - Lbits'(1);
      end
    end
  end

endmodule
